// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, mult/div busy and flush sequencing.
// Ports: clk/rst, ID source fields, EX load/md info, exc_flush -> keep/clr, md_busy, stall_cnt.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_is_md,
    input  logic        ex_load,
    input  logic [4:0]  ex_rt,
    input  logic        ex_md_start,
    input  logic        ex_md_is_div,
    input  logic        exc_flush,
    output logic        pc_keep,
    output logic        ifid_keep,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic lu, md, stall, rs_hit, rt_hit;

    assign md_busy = (state_q == BUSY);

    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign rs_hit = id_use_rs & (id_rs == ex_rt);
    assign rt_hit = id_use_rt & (id_rt == ex_rt);
    assign lu     = ex_load & (ex_rt != 5'd0) & (rs_hit | rt_hit);
    assign md     = id_is_md & (md_busy | ex_md_start);
    assign stall  = (lu | md) & ~exc_flush;

    // Flush wins: keep drops so the IF/ID clear takes effect.
    assign pc_keep   = stall;
    assign ifid_keep = stall;
    assign ifid_clr  = exc_flush;
    assign idex_clr  = stall | exc_flush;
    assign stall_cnt = stall_cnt_q;

    // A flushed start never reached the unit; an in-flight op keeps running.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (ex_md_start && !exc_flush) begin
                    cnt_d   = ex_md_is_div ? DIV_LD : MULT_LD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_cnt_d = stall_cnt_q + {31'd0, stall};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
